wakeup_tag_arbiter: RTL and testbench
=====================================

# wakeup_tag_arbiter

Collects destination-tag wakeup broadcasts from NUM_REQ producers and drives them onto the NUM_PORTS tag inputs of the issue-queue wakeup CAM. Producers include ALU, AGEN, load-return and replay paths. Each producer has a small per-requester FIFO, and a rotating-priority arbiter grants at most one tag per requester and at most NUM_PORTS tags per cycle. It sits between the execute-stage writeback tag sources and the wakeup CAM. Outputs are registered so CAM match logic starts at a clean clock edge.

## Interface
- NUM_REQ, 4: number of tag producers.
- NUM_PORTS, `ISSUE_WIDTH: number of CAM broadcast (tag compare) ports.
- WIDTH, 8: physical tag width; the all-ones value is reserved (NULL_TAG) and never allocated.
- FIFO_DEPTH, 4: entries per requester FIFO; power of two, ≥2.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  pipeline flush (recovery); discards all buffered tags.
- req_valid_i  in  NUM_REQ  requester r presents a tag.
- req_tag_i  in  NUM_REQ×WIDTH  tag from requester r.
- req_ready_o  out  NUM_REQ  requester r's FIFO can accept this cycle.
- tag_o  out  NUM_PORTS×WIDTH  broadcast tags to CAM tag inputs.
- tag_valid_o  out  NUM_PORTS  port p carries a real tag.

## Operation
- Enqueue: a tag is written into FIFO r when req_valid_i[r] && req_ready_o[r].
- Ready: req_ready_o[r] = (count[r] < FIFO_DEPTH) && !flush_i && reset high. It is computed from registered count only, with no same-cycle dequeue credit.
- Arbitration is combinational on the FIFO heads:
  - Scan requesters rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Grant the first NUM_PORTS non-empty FIFOs.
  - Port 0 gets the first grant, port 1 the second, and so on.
- Each granted FIFO pops exactly one entry. Simultaneous push and pop on the same FIFO is legal; count is unchanged.
- Output register:
  - Granted port p loads tag_o[p] = head tag and tag_valid_o[p] = 1.
  - Ungranted ports load tag_o[p] = NULL_TAG and tag_valid_o[p] = 0, so the CAM never matches a stale tag.
- rr_ptr update:
  - If ≥1 grant, rr_ptr ← (index of last granted requester + 1) mod NUM_REQ.
  - With zero grants, rr_ptr holds.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Per-requester tag order is preserved. There is no ordering guarantee across requesters.
- Flush, when flush_i is high at an edge:
  - All counts and pointers go to 0 and no pops occur.
  - Outputs load NULL_TAG with valid 0.
  - Enqueues in the flush cycle are dropped (ready is low).
  - rr_ptr holds.
- No duplicate-tag filtering; producers guarantee uniqueness.

## Timing
- Reset values (asynchronous, while reset is low):
  - All FIFOs empty.
  - rr_ptr = 0.
  - tag_valid_o = 0 and tag_o = NULL_TAG on all ports.
  - req_ready_o = 0.
- req_ready_o rises combinationally once reset deasserts.
- Latency: a tag accepted at edge E0 is at the FIFO head after E0. If granted, it is registered at E0+1 and visible on tag_o in the cycle after E0+1 (2 cycles, minimum).
- Throughput: min(NUM_PORTS, non-empty requesters) tags per cycle, with one per requester.
- Full FIFO: ready is low for that cycle even if that FIFO pops in the same cycle. It rises the cycle after a pop.
- Reset asserted mid-operation: all buffered tags are lost immediately. No partial broadcasts occur.

## Configuration
- WAKEUP_ARB_PERF_EN defined:
  - Adds output stall_cnt_o [31:0].
  - It increments by 1 on each edge where any bit of req_valid_i & ~req_ready_o is set.
  - It wraps at 2^32, resets to 0, and is not cleared by flush_i.
- Undefined: the port and the counter are absent. Functional behaviour is identical.

## Structure
- Shared package holds NULL_TAG = {WIDTH{1'b1}}, the tag typedef, and the helper function rr_next(ptr, last).
- One sub-module, wakeup_tag_fifo: a single-requester FIFO with push/pop/count/head, instantiated NUM_REQ times via generate.
- Arbiter, rr_ptr and output register live in the top module.

## Test plan
- Reset then idle: after reset deasserts, tag_valid_o = 0, tag_o = 0xFF on all ports, req_ready_o = 4'b1111.
- Single tag: requester 2 pushes 0x15 at E0 → tag_o[0] = 0x15 with valid in the cycle after E0+1; port 1 is NULL; rr_ptr = 3.
- Contention (NUM_PORTS=2): all 4 requesters push tags 0x10–0x13 in one cycle with rr_ptr = 0.
  - First broadcast is {0x10, 0x11}, then {0x12, 0x13}.
  - rr_ptr ends at 0.
- Back-pressure: requester 0 pushes 5 tags back-to-back while ports are consumed by higher-priority traffic.
  - ready[0] drops after the 4th accept; the 5th is held.
  - The 5th is accepted the cycle after the first pop.
  - Order 0x20..0x24 is preserved on output.
- Flush: with 3 tags buffered, assert flush_i for one cycle.
  - Next cycle all valids are 0 and no buffered tag ever appears.
  - A push presented during flush is dropped.
  - rr_ptr is unchanged.
- PERF_EN: hold requester 1 full for 6 cycles with valid high → stall_cnt_o = 6. Async reset mid-stream → stall_cnt_o = 0 and all outputs are at reset values immediately.

Source files
------------

// File: rtl/wakeup_tag_arbiter_pkg.sv
// rtl/wakeup_tag_arbiter_pkg.sv - shared tag type, NULL tag and round-robin helper
// ISSUE_WIDTH sets the CAM broadcast port count (defaults to 2 when not supplied).
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

package wakeup_tag_arbiter_pkg;

  localparam int TAG_WIDTH = 8;

  typedef logic [TAG_WIDTH-1:0] tag_t;

  // The all-ones tag is never allocated, so the CAM can never match it.
  localparam tag_t NULL_TAG = {TAG_WIDTH{1'b1}};

  function automatic int rr_next(input int ptr, input int last, input logic granted,
                                 input int num_req);
    return granted ? (last + 1) % num_req : ptr;
  endfunction

endpackage

// File: rtl/wakeup_tag_fifo.sv
// rtl/wakeup_tag_fifo.sv - single-requester tag FIFO with push/pop, count and head
module wakeup_tag_fifo
  import wakeup_tag_arbiter_pkg::*;
#(
  parameter int WIDTH = TAG_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_tag,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_tag;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wakeup_tag_arbiter.sv
// rtl/wakeup_tag_arbiter.sv - rotating-priority wakeup tag arbiter feeding the CAM ports
// Optional WAKEUP_ARB_PERF_EN adds a 32-bit producer stall counter output.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

module wakeup_tag_arbiter
  import wakeup_tag_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_PORTS  = `ISSUE_WIDTH,
  parameter int WIDTH      = TAG_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_tag_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_PORTS*WIDTH-1:0] tag_o,
  output logic [NUM_PORTS-1:0]       tag_valid_o
`ifdef WAKEUP_ARB_PERF_EN
  ,
  output logic [31:0]                stall_cnt_o
`endif
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WIDTH-1:0] NULL_T = {WIDTH{1'b1}};

  logic [RW-1:0]      rr_ptr;
  logic [RW-1:0]      rr_upd;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] nonempty;
  logic [WIDTH-1:0]   head  [NUM_REQ];
  logic [CW-1:0]      count [NUM_REQ];
  logic [RW-1:0]      sel   [NUM_PORTS];
  logic [NUM_PORTS-1:0] sel_valid;
  logic [RW-1:0]      arb_idx;
  logic [RW-1:0]      arb_last;
  int                 arb_n;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
    // Ready looks at registered count only; a same-cycle pop gives no credit.
    assign req_ready_o[r] = reset && !flush_i && (count[r] < CW'(FIFO_DEPTH));
    assign push[r]        = req_valid_i[r] && req_ready_o[r];
    assign pop[r]         = grant[r] && !flush_i;
    assign nonempty[r]    = (count[r] != '0);

    wakeup_tag_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush_i),
      .push     (push[r]),
      .push_tag (req_tag_i[r*WIDTH +: WIDTH]),
      .pop      (pop[r]),
      .head     (head[r]),
      .count    (count[r])
    );
  end

  always_comb begin
    grant     = '0;
    sel_valid = '0;
    arb_n     = 0;
    arb_idx   = '0;
    arb_last  = '0;
    for (int p = 0; p < NUM_PORTS; p++) sel[p] = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_idx = RW'((int'(rr_ptr) + k) % NUM_REQ);
      if (nonempty[arb_idx] && arb_n < NUM_PORTS) begin
        grant[arb_idx] = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (p == arb_n) begin
            sel[p]       = arb_idx;
            sel_valid[p] = 1'b1;
          end
        end
        arb_last = arb_idx;
        arb_n    = arb_n + 1;
      end
    end
    rr_upd = RW'(rr_next(int'(rr_ptr), int'(arb_last), |grant, NUM_REQ));
  end

  // Ungranted ports are forced to NULL so the CAM never sees a stale tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= '0;
      tag_valid_o <= '0;
      tag_o       <= {NUM_PORTS{NULL_T}};
    end else if (flush_i) begin
      tag_valid_o <= '0;
      tag_o       <= {NUM_PORTS{NULL_T}};
    end else begin
      rr_ptr <= rr_upd;
      for (int p = 0; p < NUM_PORTS; p++) begin
        tag_valid_o[p]           <= sel_valid[p];
        tag_o[p*WIDTH +: WIDTH]  <= sel_valid[p] ? head[sel[p]] : NULL_T;
      end
    end
  end

`ifdef WAKEUP_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= '0;
    end else if (|(req_valid_i & ~req_ready_o)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wakeup_tag_arbiter.sv
// tb/tb_wakeup_tag_arbiter.sv - scoreboard bench for a 2-port and a 1-port wakeup_tag_arbiter
module tb_wakeup_tag_arbiter;
  import wakeup_tag_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  a_valid = '0;
  logic [31:0] a_tag = '0;
  logic [3:0]  a_ready;
  logic [15:0] a_tago;
  logic [1:0]  a_tv;
  logic [3:0]  b_valid = '0;
  logic [31:0] b_tag = '0;
  logic [3:0]  b_ready;
  logic [7:0]  b_tago;
  logic [0:0]  b_tv;
`ifdef WAKEUP_ARB_PERF_EN
  logic [31:0] a_stall;
  logic [31:0] b_stall;
`endif

  int   tests_run = 0;
  int   tests_failed = 0;
  bit   mon_en = 1'b0;
  tag_t qa [4][$];
  tag_t qb [$];
  tag_t mt;
  bit   mhit;

  always #5 clk = ~clk;

  wakeup_tag_arbiter #(.NUM_REQ(4), .NUM_PORTS(2), .WIDTH(8), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .flush_i(flush), .req_valid_i(a_valid), .req_tag_i(a_tag),
    .req_ready_o(a_ready), .tag_o(a_tago), .tag_valid_o(a_tv)
`ifdef WAKEUP_ARB_PERF_EN
    , .stall_cnt_o(a_stall)
`endif
  );

  wakeup_tag_arbiter #(.NUM_REQ(4), .NUM_PORTS(1), .WIDTH(8), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .flush_i(flush), .req_valid_i(b_valid), .req_tag_i(b_tag),
    .req_ready_o(b_ready), .tag_o(b_tago), .tag_valid_o(b_tv)
`ifdef WAKEUP_ARB_PERF_EN
    , .stall_cnt_o(b_stall)
`endif
  );

  // Every broadcast must be the oldest outstanding tag of some requester.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        mt = a_tago[p*8 +: 8];
        mhit = 1'b0;
        tests_run++;
        if (a_tv[p]) begin
          for (int r = 0; r < 4; r++) begin
            if (!mhit && qa[r].size() > 0 && qa[r][0] == mt) begin
              void'(qa[r].pop_front());
              mhit = 1'b1;
            end
          end
          if (!mhit) begin
            tests_failed++;
            $display("FAIL a_sb port %0d: got tag %h, expected a queued requester head", p, mt);
          end
        end else if (mt !== NULL_TAG) begin
          tests_failed++;
          $display("FAIL a_null port %0d: got %h expected %h", p, mt, NULL_TAG);
        end
      end
      tests_run++;
      if (b_tv[0]) begin
        if (qb.size() == 0 || qb[0] != b_tago) begin
          tests_failed++;
          $display("FAIL b_sb: got tag %h expected %h", b_tago, (qb.size() > 0) ? qb[0] : NULL_TAG);
        end else begin
          void'(qb.pop_front());
        end
      end else if (b_tago !== NULL_TAG) begin
        tests_failed++;
        $display("FAIL b_null: got %h expected %h", b_tago, NULL_TAG);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int r, input tag_t t);
    a_valid[r] = 1'b1;
    a_tag[r*8 +: 8] = t;
    qa[r].push_back(t);
  endtask

  task automatic clear_sb();
    for (int r = 0; r < 4; r++) qa[r].delete();
    qb.delete();
  endtask

  task automatic test_reset();
    tick();
    tests_run++;
    if (a_tv !== 2'b00 || a_tago !== 16'hFFFF || a_ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_held_a: got tv=%b tag=%h rdy=%b expected tv=00 tag=ffff rdy=0000", a_tv, a_tago, a_ready);
    end
    tests_run++;
    if (b_tv !== 1'b0 || b_tago !== 8'hFF || b_ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_held_b: got tv=%b tag=%h rdy=%b expected tv=0 tag=ff rdy=0000", b_tv, b_tago, b_ready);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (a_ready !== 4'hF || b_ready !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_ready: got a=%b b=%b expected 1111", a_ready, b_ready);
    end
    tick();
    tests_run++;
    if (a_tv !== 2'b00 || a_tago !== 16'hFFFF || u_a.rr_ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got tv=%b tag=%h rr=%0d expected tv=00 tag=ffff rr=0", a_tv, a_tago, u_a.rr_ptr);
    end
    mon_en = 1'b1;
  endtask

`ifdef WAKEUP_ARB_PERF_EN
  task automatic test_perf();
    flush = 1'b1;
    a_valid[1] = 1'b1;
    a_tag[15:8] = 8'h60;
    repeat (6) tick();
    flush = 1'b0;
    a_valid = '0;
    tests_run++;
    if (a_stall !== 32'd6 || b_stall !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_stall: got a=%0d b=%0d expected a=6 b=0", a_stall, b_stall);
    end
    push_a(0, 8'h55);
    tick();
    a_valid = '0;
    push_a(1, 8'h56);
    tick();
    a_valid = '0;
    tests_run++;
    if (a_tv !== 2'b01 || a_tago[7:0] !== 8'h55) begin
      tests_failed++;
      $display("FAIL perf_pre_reset: got tv=%b tag=%h expected tv=01 tag=55", a_tv, a_tago[7:0]);
    end
    #2 reset = 1'b0;
    #1;
    clear_sb();
    tests_run++;
    if (a_tv !== 2'b00 || a_tago !== 16'hFFFF || a_ready !== 4'h0 || a_stall !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_async_reset: got tv=%b tag=%h rdy=%b stall=%0d expected 00 ffff 0000 0", a_tv, a_tago, a_ready, a_stall);
    end
    tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask
`endif

  task automatic test_single();
    push_a(2, 8'h15);
    tick();
    a_valid = '0;
    tick();
    tests_run++;
    if (a_tv !== 2'b01 || a_tago !== 16'hFF15) begin
      tests_failed++;
      $display("FAIL single_out: got tv=%b tag=%h expected tv=01 tag=ff15", a_tv, a_tago);
    end
    tests_run++;
    if (u_a.rr_ptr !== 2'd3) begin
      tests_failed++;
      $display("FAIL single_rr: got %0d expected 3", u_a.rr_ptr);
    end
    tick();
    tests_run++;
    if (a_tv !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_after: got tv=%b expected 00", a_tv);
    end
  endtask

  task automatic test_contention();
    push_a(3, 8'h05);
    tick();
    a_valid = '0;
    tick();
    tests_run++;
    if (u_a.rr_ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL cont_rr_start: got %0d expected 0", u_a.rr_ptr);
    end
    for (int r = 0; r < 4; r++) push_a(r, 8'(8'h10 + r));
    tick();
    a_valid = '0;
    tick();
    tests_run++;
    if (a_tv !== 2'b11 || a_tago !== 16'h1110) begin
      tests_failed++;
      $display("FAIL cont_first: got tv=%b tag=%h expected tv=11 tag=1110", a_tv, a_tago);
    end
    tick();
    tests_run++;
    if (a_tv !== 2'b11 || a_tago !== 16'h1312) begin
      tests_failed++;
      $display("FAIL cont_second: got tv=%b tag=%h expected tv=11 tag=1312", a_tv, a_tago);
    end
    tests_run++;
    if (u_a.rr_ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL cont_rr_end: got %0d expected 0", u_a.rr_ptr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    b_valid[0] = 1'b1;
    b_tag[7:0] = 8'h0A;
    qb.push_back(8'h0A);
    tick();
    b_valid = '0;
    tick();
    tests_run++;
    if (u_b.rr_ptr !== 2'd1) begin
      tests_failed++;
      $display("FAIL bp_rr_warm: got %0d expected 1", u_b.rr_ptr);
    end
    tick();
    b_valid = 4'b1111;
    b_tag = {8'h43, 8'h42, 8'h41, 8'h20};
    qb.push_back(8'h41);
    qb.push_back(8'h42);
    qb.push_back(8'h43);
    for (int i = 0; i < 5; i++) qb.push_back(8'(8'h20 + i));
    tick();
    b_valid = 4'b0001;
    b_tag[7:0] = 8'h21;
    tests_run++;
    if (b_ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_one: got %b expected 1", b_ready[0]);
    end
    tick();
    b_tag[7:0] = 8'h22;
    tick();
    b_tag[7:0] = 8'h23;
    tick();
    b_tag[7:0] = 8'h24;
    tests_run++;
    if (b_ready[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: got ready %b expected 0", b_ready[0]);
    end
    tick();
    tests_run++;
    if (b_ready[0] !== 1'b1 || b_tv !== 1'b1 || b_tago !== 8'h20) begin
      tests_failed++;
      $display("FAIL bp_reopen: got rdy=%b tv=%b tag=%h expected 1 1 20", b_ready[0], b_tv, b_tago);
    end
    tick();
    b_valid = '0;
    repeat (5) tick();
    tests_run++;
    if (qb.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_drain: got %0d tags outstanding expected 0", qb.size());
    end
  endtask

  task automatic test_flush();
    push_a(0, 8'h30);
    push_a(1, 8'h31);
    push_a(2, 8'h32);
    tick();
    a_valid = '0;
    flush = 1'b1;
    a_valid[3] = 1'b1;
    a_tag[31:24] = 8'h3F;
    clear_sb();
    #1;
    tests_run++;
    if (a_ready !== 4'h0) begin
      tests_failed++;
      $display("FAIL flush_ready: got %b expected 0000", a_ready);
    end
    tick();
    flush = 1'b0;
    a_valid = '0;
    tests_run++;
    if (a_tv !== 2'b00 || a_tago !== 16'hFFFF || u_a.rr_ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL flush_out: got tv=%b tag=%h rr=%0d expected 00 ffff 0", a_tv, a_tago, u_a.rr_ptr);
    end
    tick();
    tests_run++;
    if (a_tv !== 2'b00 || a_ready !== 4'hF) begin
      tests_failed++;
      $display("FAIL flush_after: got tv=%b rdy=%b expected 00 1111", a_tv, a_ready);
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
`ifdef WAKEUP_ARB_PERF_EN
    test_perf();
`endif
    test_single();
    test_contention();
    test_back_to_back();
    test_flush();
    tests_run++;
    if (qa[0].size() + qa[1].size() + qa[2].size() + qa[3].size() != 0) begin
      tests_failed++;
      $display("FAIL sb_empty: got %0d tags never broadcast expected 0",
               qa[0].size() + qa[1].size() + qa[2].size() + qa[3].size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
